simt_reconvergence_stack: RTL and testbench
===========================================

# simt_reconvergence_stack

Per-warp SIMT reconvergence stack for the compute unit. It replaces the PC-increment-only warp tracker with real divergence handling. On a divergent branch reported by decode, it splits the active mask, pushes the not-taken path and the reconvergence point onto a per-warp stack of configurable depth, and pops them when the warp reaches the reconvergence PC. It sits between the thread-block dispatcher, the fetcher (ready/PC/mask) and decode (next-PC/branch info).

## Interface
- `PcWidth`, 32, PC width
- `NumWarps`, 32, warps per compute unit
- `WarpWidth`, 32, threads per warp
- `StackDepth`, 8, stack entries per warp (≥2)
- `TblockIdxBits`, 4, thread-block index width
- `TblockIdBits`, 4, thread-block id width
- `AddressWidth`, 32, data/parameter address width
- `clk_i` in 1 clock
- `rst_ni` in 1 reset; **one clock; reset is synchronous and active-low**
- `warp_free_o` out 1 at least one unoccupied warp
- `allocate_warp_i` in 1 allocate request
- `allocate_pc_i` in PcWidth start PC
- `allocate_dp_addr_i` in AddressWidth data/parameter address
- `allocate_tblock_idx_i` in TblockIdxBits block index
- `allocate_tblock_id_i` in TblockIdBits block id
- `tblock_done_o` out 1 pulse: warp stopped
- `tblock_done_id_o` out TblockIdBits id of the stopped block
- `instruction_decoded_i` in 1 decode update valid
- `decode_wid_i` in clog2(NumWarps) decoded warp
- `decode_stop_warp_i` in 1 warp terminates
- `decode_next_pc_i` in PcWidth fall-through PC
- `decode_branch_i` in 1 instruction is a conditional branch
- `decode_taken_mask_i` in WarpWidth threads taking the branch
- `decode_target_pc_i` in PcWidth branch target
- `decode_reconv_pc_i` in PcWidth immediate post-dominator of the branch
- `warp_selected_i` in NumWarps fetch selection one-hot
- `warp_ready_o` out NumWarps warp may be fetched
- `warp_pc_o` out NumWarps×PcWidth current PC
- `warp_act_mask_o` out NumWarps×WarpWidth active mask
- `warp_dp_addr_o` out NumWarps×AddressWidth data/parameter address
- `warp_tblock_idx_o` out NumWarps×TblockIdxBits block index
- `stack_overflow_o` out 1 pulse: push rejected
- `stack_overflow_wid_o` out clog2(NumWarps) offending warp

## Operation
- Per-warp state: occupied, ready, halted, pc, act_mask, rpc (current reconvergence PC; `'1` = none), sp (0..StackDepth), dp_addr, tblock_idx, tblock_id, and a stack of {pc, mask, rpc}.
- Allocate: when `allocate_warp_i && warp_free_o`, take the lowest-index unoccupied warp. Set pc = allocate_pc, mask = `'1`, rpc = `'1`, sp = 0, ready = 1, halted = 0.
- Decode update for warp w, with t = taken_mask & act_mask:
  - **Non-branch, or t == 0:** pc = next_pc.
  - **t == act_mask:** pc = target.
  - **Divergent (0 < t < act_mask), requires sp ≤ StackDepth-2:**
    - push {rpc_pc = reconv_pc, act_mask, rpc};
    - push {next_pc, act_mask & ~t, reconv_pc};
    - set pc = target, mask = t, rpc = reconv_pc, sp += 2.
  - **Divergent with sp > StackDepth-2:** no push. Set halted = 1 and pulse `stack_overflow_o` with w. The warp stays occupied and never becomes ready again until reset.
  - In all non-halt cases ready = 1.
- Stop: `decode_stop_warp_i` takes priority over the branch rules. It clears occupied, ready and sp, and pulses `tblock_done_o` with the stored tblock_id.
- Pop: for each warp with occupied, sp > 0 and pc == rpc (registered state), load {pc, mask, rpc} from stack[sp-1] and decrement sp.
  - At most one pop per warp per cycle.
  - Chained reconvergence takes successive cycles.
- Selection: `warp_selected_i[w]` clears ready. Selection has priority over a same-cycle decode ready-set only on other warps; the same warp selected and decoded in one cycle is illegal.
- `warp_ready_o[w]` = ready & occupied & !halted & |mask & !(sp > 0 && pc == rpc).

## Timing
- All state is registered; outputs are driven from registers, except `warp_free_o`, the pulses and the done/overflow ids, which are combinational from the current inputs and state.
- Decode, allocate and pop take effect on the next rising edge.
- A warp is fetchable again one cycle after its decode update (two or more if pops are pending).
- Allocate and stop in the same cycle never target the same warp, because allocation uses the registered occupied bit.
- Reset (synchronous, `rst_ni` low at an edge), including mid-divergence:
  - all state → 0 and all stacks cleared;
  - `warp_ready_o`, `warp_pc_o`, `warp_act_mask_o`, `warp_dp_addr_o`, `warp_tblock_idx_o` = 0;
  - `tblock_done_o`, `tblock_done_id_o`, `stack_overflow_o`, `stack_overflow_wid_o` = 0 while reset is held;
  - `warp_free_o` = 1.

## Configuration
- `SIMT_RS_PERF_CNT_EN` defined: adds output `divergence_count_o` (32 bits). It increments by one for each accepted divergent push and saturates at `'1`.
- Macro undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then allocate pc=0x100 → warp 0 ready, mask `'1`, pc 0x100; `warp_free_o`=1 while NumWarps>1.
- Warp 0 branch with taken=0x0000FFFF, target 0x200, next 0x104, reconv 0x300 → next cycle pc 0x200, mask 0x0000FFFF, sp 2.
- Same warp decodes next_pc=0x300:
  - pop cycle: pc 0x104, mask 0xFFFF0000, not ready until the pop completes;
  - after reaching 0x300 again: pop restores mask `'1`, sp 0.
- Uniform branches: taken == mask → pc = target with no push; taken == 0 → pc = next_pc.
- StackDepth=2 with a nested divergent branch → `stack_overflow_o` pulses with the wid, the warp halts, and other warps are unaffected.
- Stop with sp=2 → `tblock_done_o` with the correct id; the warp is free and its next allocation starts with sp 0.

Source files
------------

// File: rtl/simt_reconvergence_stack.sv
// Per-warp SIMT reconvergence stack: splits active masks on divergent branches and
// pops {pc, mask, rpc} at the reconvergence PC. Define SIMT_RS_PERF_CNT_EN for divergence_count_o.
module simt_reconvergence_stack #(
    parameter int PcWidth       = 32,
    parameter int NumWarps      = 32,
    parameter int WarpWidth     = 32,
    parameter int StackDepth    = 8,
    parameter int TblockIdxBits = 4,
    parameter int TblockIdBits  = 4,
    parameter int AddressWidth  = 32,
    localparam int WidW         = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    output logic                              warp_free_o,
    input  logic                              allocate_warp_i,
    input  logic [PcWidth-1:0]                allocate_pc_i,
    input  logic [AddressWidth-1:0]           allocate_dp_addr_i,
    input  logic [TblockIdxBits-1:0]          allocate_tblock_idx_i,
    input  logic [TblockIdBits-1:0]           allocate_tblock_id_i,
    output logic                              tblock_done_o,
    output logic [TblockIdBits-1:0]           tblock_done_id_o,
    input  logic                              instruction_decoded_i,
    input  logic [WidW-1:0]                   decode_wid_i,
    input  logic                              decode_stop_warp_i,
    input  logic [PcWidth-1:0]                decode_next_pc_i,
    input  logic                              decode_branch_i,
    input  logic [WarpWidth-1:0]              decode_taken_mask_i,
    input  logic [PcWidth-1:0]                decode_target_pc_i,
    input  logic [PcWidth-1:0]                decode_reconv_pc_i,
    input  logic [NumWarps-1:0]               warp_selected_i,
    output logic [NumWarps-1:0]               warp_ready_o,
    output logic [NumWarps*PcWidth-1:0]       warp_pc_o,
    output logic [NumWarps*WarpWidth-1:0]     warp_act_mask_o,
    output logic [NumWarps*AddressWidth-1:0]  warp_dp_addr_o,
    output logic [NumWarps*TblockIdxBits-1:0] warp_tblock_idx_o,
`ifdef SIMT_RS_PERF_CNT_EN
    output logic [31:0]                       divergence_count_o,
`endif
    output logic                              stack_overflow_o,
    output logic [WidW-1:0]                   stack_overflow_wid_o
);

    localparam int SpW  = $clog2(StackDepth + 1);
    localparam int StkW = $clog2(StackDepth);
    localparam logic [SpW-1:0] SpPushMax = SpW'(StackDepth - 2);

    logic [NumWarps-1:0]                                occ_q, occ_d, rdy_q, rdy_d, halt_q, halt_d;
    logic [NumWarps-1:0][PcWidth-1:0]                   pc_q, pc_d, rpc_q, rpc_d;
    logic [NumWarps-1:0][WarpWidth-1:0]                 mask_q, mask_d;
    logic [NumWarps-1:0][SpW-1:0]                       sp_q, sp_d;
    logic [NumWarps-1:0][AddressWidth-1:0]              dp_q, dp_d;
    logic [NumWarps-1:0][TblockIdxBits-1:0]             idx_q, idx_d;
    logic [NumWarps-1:0][TblockIdBits-1:0]              id_q, id_d;
    logic [NumWarps-1:0][StackDepth-1:0][PcWidth-1:0]   stk_pc_q, stk_pc_d, stk_rpc_q, stk_rpc_d;
    logic [NumWarps-1:0][StackDepth-1:0][WarpWidth-1:0] stk_mask_q, stk_mask_d;

    logic [NumWarps-1:0]  alloc_oh, dec_hit, pop_pend, mask_nz;
    logic                 alloc_found;
    logic [WarpWidth-1:0] dec_taken;
    logic                 dec_live, dec_div, dec_push, dec_ovf;

    // Decode-side classification of the branch for the addressed warp.
    always_comb begin
        dec_taken = decode_taken_mask_i & mask_q[decode_wid_i];
        dec_live  = instruction_decoded_i && !decode_stop_warp_i &&
                    occ_q[decode_wid_i] && !halt_q[decode_wid_i];
        dec_div   = decode_branch_i && (dec_taken != '0) && (dec_taken != mask_q[decode_wid_i]);
        dec_push  = dec_live && dec_div && (sp_q[decode_wid_i] <= SpPushMax);
        dec_ovf   = dec_live && dec_div && (sp_q[decode_wid_i] > SpPushMax);
    end

    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        dec_hit     = '0;
        pop_pend    = '0;
        mask_nz     = '0;
        for (int w = 0; w < NumWarps; w++) begin
            if (!occ_q[w] && !alloc_found) begin
                alloc_oh[w] = allocate_warp_i;
                alloc_found = 1'b1;
            end
            dec_hit[w]  = instruction_decoded_i && (decode_wid_i == WidW'(w));
            pop_pend[w] = occ_q[w] && (sp_q[w] != '0) && (pc_q[w] == rpc_q[w]);
            mask_nz[w]  = |mask_q[w];
        end
    end

    always_comb begin
        occ_d = occ_q;  rdy_d = rdy_q;  halt_d = halt_q;
        pc_d  = pc_q;   rpc_d = rpc_q;  mask_d = mask_q;  sp_d = sp_q;
        dp_d  = dp_q;   idx_d = idx_q;  id_d   = id_q;
        stk_pc_d = stk_pc_q;  stk_rpc_d = stk_rpc_q;  stk_mask_d = stk_mask_q;
        for (int w = 0; w < NumWarps; w++) begin
            if (warp_selected_i[w]) rdy_d[w] = 1'b0;
            if (alloc_oh[w]) begin
                occ_d[w]  = 1'b1;
                rdy_d[w]  = 1'b1;
                halt_d[w] = 1'b0;
                pc_d[w]   = allocate_pc_i;
                mask_d[w] = '1;
                rpc_d[w]  = '1;
                sp_d[w]   = '0;
                dp_d[w]   = allocate_dp_addr_i;
                idx_d[w]  = allocate_tblock_idx_i;
                id_d[w]   = allocate_tblock_id_i;
            end else if (dec_hit[w] && decode_stop_warp_i && occ_q[w]) begin
                occ_d[w] = 1'b0;
                rdy_d[w] = 1'b0;
                sp_d[w]  = '0;
            end else if (dec_hit[w] && dec_live) begin
                if (dec_ovf) begin
                    halt_d[w] = 1'b1;
                end else begin
                    rdy_d[w] = 1'b1;
                    if (dec_push) begin
                        // Lower entry resumes the full mask at reconvergence; upper runs the not-taken side.
                        stk_pc_d[w][StkW'(sp_q[w])]              = decode_reconv_pc_i;
                        stk_mask_d[w][StkW'(sp_q[w])]            = mask_q[w];
                        stk_rpc_d[w][StkW'(sp_q[w])]             = rpc_q[w];
                        stk_pc_d[w][StkW'(sp_q[w] + SpW'(1))]   = decode_next_pc_i;
                        stk_mask_d[w][StkW'(sp_q[w] + SpW'(1))] = mask_q[w] & ~dec_taken;
                        stk_rpc_d[w][StkW'(sp_q[w] + SpW'(1))]  = decode_reconv_pc_i;
                        pc_d[w]   = decode_target_pc_i;
                        mask_d[w] = dec_taken;
                        rpc_d[w]  = decode_reconv_pc_i;
                        sp_d[w]   = sp_q[w] + SpW'(2);
                    end else if (decode_branch_i && (dec_taken != '0) && (dec_taken == mask_q[w])) begin
                        pc_d[w] = decode_target_pc_i;
                    end else begin
                        pc_d[w] = decode_next_pc_i;
                    end
                end
            end else if (pop_pend[w]) begin
                pc_d[w]   = stk_pc_q[w][StkW'(sp_q[w] - SpW'(1))];
                mask_d[w] = stk_mask_q[w][StkW'(sp_q[w] - SpW'(1))];
                rpc_d[w]  = stk_rpc_q[w][StkW'(sp_q[w] - SpW'(1))];
                sp_d[w]   = sp_q[w] - SpW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q <= '0;  rdy_q <= '0;  halt_q <= '0;
            pc_q  <= '0;  rpc_q <= '0;  mask_q <= '0;  sp_q <= '0;
            dp_q  <= '0;  idx_q <= '0;  id_q   <= '0;
            stk_pc_q <= '0;  stk_rpc_q <= '0;  stk_mask_q <= '0;
        end else begin
            occ_q <= occ_d;  rdy_q <= rdy_d;  halt_q <= halt_d;
            pc_q  <= pc_d;   rpc_q <= rpc_d;  mask_q <= mask_d;  sp_q <= sp_d;
            dp_q  <= dp_d;   idx_q <= idx_d;  id_q   <= id_d;
            stk_pc_q <= stk_pc_d;  stk_rpc_q <= stk_rpc_d;  stk_mask_q <= stk_mask_d;
        end
    end

`ifdef SIMT_RS_PERF_CNT_EN
    logic [31:0] div_cnt_q, div_cnt_d;
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (dec_push && (div_cnt_q != '1)) div_cnt_d = div_cnt_q + 32'd1;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) div_cnt_q <= '0;
        else         div_cnt_q <= div_cnt_d;
    end
    assign divergence_count_o = div_cnt_q;
`endif

    assign warp_free_o          = !rst_ni || !(&occ_q);
    assign warp_ready_o         = rdy_q & occ_q & ~halt_q & mask_nz & ~pop_pend;
    assign warp_pc_o            = pc_q;
    assign warp_act_mask_o      = mask_q;
    assign warp_dp_addr_o       = dp_q;
    assign warp_tblock_idx_o    = idx_q;
    assign tblock_done_o        = rst_ni && instruction_decoded_i && decode_stop_warp_i && occ_q[decode_wid_i];
    assign tblock_done_id_o     = tblock_done_o ? id_q[decode_wid_i] : '0;
    assign stack_overflow_o     = rst_ni && dec_ovf;
    assign stack_overflow_wid_o = stack_overflow_o ? decode_wid_i : '0;

endmodule

// File: tb/tb_simt_reconvergence_stack.sv
// Bench for simt_reconvergence_stack: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the reconvergence stacks.
module tb_simt_reconvergence_stack;
    localparam int NW = 4, PW = 32, WW = 32, AW = 32, IXW = 4, IDW = 4, DEPTH = 2, WIDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            alloc, dec, stop, br;
    logic [PW-1:0]   a_pc, npc, tgt, rcv;
    logic [AW-1:0]   a_dp;
    logic [IXW-1:0]  a_idx;
    logic [IDW-1:0]  a_id;
    logic [WIDW-1:0] wid;
    logic [WW-1:0]   tmask;
    logic [NW-1:0]   sel;

    logic            warp_free, done, ovf;
    logic [IDW-1:0]  done_id;
    logic [WIDW-1:0] ovf_wid;
    logic [NW-1:0]   ready;
    logic [NW*PW-1:0]  pcs;
    logic [NW*WW-1:0]  masks;
    logic [NW*AW-1:0]  dps;
    logic [NW*IXW-1:0] idxs;

    simt_reconvergence_stack #(
        .PcWidth(PW), .NumWarps(NW), .WarpWidth(WW), .StackDepth(DEPTH),
        .TblockIdxBits(IXW), .TblockIdBits(IDW), .AddressWidth(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .warp_free_o(warp_free),
        .allocate_warp_i(alloc), .allocate_pc_i(a_pc), .allocate_dp_addr_i(a_dp),
        .allocate_tblock_idx_i(a_idx), .allocate_tblock_id_i(a_id),
        .tblock_done_o(done), .tblock_done_id_o(done_id),
        .instruction_decoded_i(dec), .decode_wid_i(wid), .decode_stop_warp_i(stop),
        .decode_next_pc_i(npc), .decode_branch_i(br), .decode_taken_mask_i(tmask),
        .decode_target_pc_i(tgt), .decode_reconv_pc_i(rcv),
        .warp_selected_i(sel), .warp_ready_o(ready), .warp_pc_o(pcs),
        .warp_act_mask_o(masks), .warp_dp_addr_o(dps), .warp_tblock_idx_o(idxs),
        .stack_overflow_o(ovf), .stack_overflow_wid_o(ovf_wid)
    );

    // Reference model: each warp's stack is a queue of {pc, mask, rpc}.
    typedef struct { logic [PW-1:0] pc; logic [WW-1:0] mask; logic [PW-1:0] rpc; } ent_t;
    bit             m_occ[NW], m_rdy[NW], m_halt[NW];
    logic [PW-1:0]  m_pc[NW], m_rpc[NW];
    logic [WW-1:0]  m_mask[NW];
    logic [AW-1:0]  m_dp[NW];
    logic [IXW-1:0] m_idx[NW];
    logic [IDW-1:0] m_id[NW];
    ent_t           m_stk[NW][$];

    int checks = 0, failures = 0;
    logic d_free, d_done, d_ovf, e_free, e_done, e_ovf;
    logic [IDW-1:0] d_done_id, e_done_id;
    logic [WIDW-1:0] d_ovf_wid, e_ovf_wid;

    function automatic logic [PW-1:0] pc_of(int w);   return pcs[w*PW +: PW];     endfunction
    function automatic logic [WW-1:0] mask_of(int w); return masks[w*WW +: WW];   endfunction
    function automatic logic [AW-1:0] dp_of(int w);   return dps[w*AW +: AW];     endfunction
    function automatic logic [IXW-1:0] idx_of(int w); return idxs[w*IXW +: IXW];  endfunction

    function automatic bit m_ready(int w);
        bit at_rpc = (m_stk[w].size() > 0) && (m_pc[w] == m_rpc[w]);
        return m_rdy[w] && m_occ[w] && !m_halt[w] && (m_mask[w] != '0) && !at_rpc;
    endfunction

    task automatic clear_inputs();
        alloc = 0; dec = 0; stop = 0; br = 0; sel = '0; wid = '0; tmask = '0;
        a_pc = '0; a_dp = '0; a_idx = '0; a_id = '0; npc = '0; tgt = '0; rcv = '0;
    endtask

    task automatic set_dec(int w, bit s, bit b, logic [WW-1:0] tm, logic [PW-1:0] n,
                           logic [PW-1:0] t, logic [PW-1:0] r);
        dec = 1; wid = WIDW'(w); stop = s; br = b; tmask = tm; npc = n; tgt = t; rcv = r;
    endtask

    // Samples the combinational outputs, advances the model and the DUT by one edge.
    task automatic tick();
        int aw;
        logic [WW-1:0] act, t;
        ent_t e;
        #1;
        d_free = warp_free; d_done = done; d_done_id = done_id; d_ovf = ovf; d_ovf_wid = ovf_wid;
        e_done = 0; e_done_id = '0; e_ovf = 0; e_ovf_wid = '0; e_free = !rst_n;
        for (int w = 0; w < NW; w++) if (!m_occ[w]) e_free = 1;
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) begin
                m_occ[w] = 0; m_rdy[w] = 0; m_halt[w] = 0; m_pc[w] = '0; m_rpc[w] = '0;
                m_mask[w] = '0; m_dp[w] = '0; m_idx[w] = '0; m_id[w] = '0; m_stk[w].delete();
            end
        end else begin
            aw = -1;
            if (alloc) for (int w = NW - 1; w >= 0; w--) if (!m_occ[w]) aw = w;
            for (int w = 0; w < NW; w++) begin
                act = m_mask[w];
                t = tmask & act;
                if (sel[w]) m_rdy[w] = 0;
                if (w == aw) begin
                    m_occ[w] = 1; m_rdy[w] = 1; m_halt[w] = 0; m_pc[w] = a_pc; m_mask[w] = '1;
                    m_rpc[w] = '1; m_stk[w].delete(); m_dp[w] = a_dp; m_idx[w] = a_idx; m_id[w] = a_id;
                end else if (dec && int'(wid) == w && stop && m_occ[w]) begin
                    e_done = 1; e_done_id = m_id[w];
                    m_occ[w] = 0; m_rdy[w] = 0; m_stk[w].delete();
                end else if (dec && int'(wid) == w && !stop && m_occ[w] && !m_halt[w]) begin
                    if (!br || t == '0) m_pc[w] = npc;
                    else if (t == act) m_pc[w] = tgt;
                    else if (m_stk[w].size() <= DEPTH - 2) begin
                        m_stk[w].push_back('{pc: rcv, mask: act, rpc: m_rpc[w]});
                        m_stk[w].push_back('{pc: npc, mask: act & ~t, rpc: rcv});
                        m_pc[w] = tgt; m_mask[w] = t; m_rpc[w] = rcv;
                    end else begin
                        m_halt[w] = 1; e_ovf = 1; e_ovf_wid = WIDW'(w);
                    end
                    if (!m_halt[w]) m_rdy[w] = 1;
                end else if (m_occ[w] && m_stk[w].size() > 0 && m_pc[w] == m_rpc[w]) begin
                    e = m_stk[w].pop_back();
                    m_pc[w] = e.pc; m_mask[w] = e.mask; m_rpc[w] = e.rpc;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs();
        set_dec(1, 1, 1, 32'h0F, 32'h4, 32'h8, 32'hC);
        tick();
        set_dec(1, 1, 1, 32'h0F, 32'h4, 32'h8, 32'hC);
        tick();
        checks++; if (d_done !== 1'b0 || d_done_id !== '0) begin failures++;
            $display("FAIL reset_done got=%b/%h want=0/0", d_done, d_done_id); end
        checks++; if (d_ovf !== 1'b0 || d_ovf_wid !== '0) begin failures++;
            $display("FAIL reset_ovf got=%b/%h want=0/0", d_ovf, d_ovf_wid); end
        checks++; if (d_free !== 1'b1) begin failures++; $display("FAIL reset_free got=%b want=1", d_free); end
        checks++; if (ready !== '0 || pcs !== '0 || masks !== '0 || dps !== '0 || idxs !== '0) begin failures++;
            $display("FAIL reset_state ready=%h pc=%h mask=%h want all 0", ready, pcs, masks); end
        rst_n = 1;
        #1;
        checks++; if (warp_free !== 1'b1) begin failures++; $display("FAIL reset_free_run got=%b want=1", warp_free); end
    endtask

    task automatic test_allocate();
        alloc = 1; a_pc = 32'h100; a_dp = 32'hA000; a_idx = 4'd3; a_id = 4'd5;
        tick();
        checks++; if (ready !== 4'b0001) begin failures++; $display("FAIL alloc_ready got=%b want=0001", ready); end
        checks++; if (pc_of(0) !== 32'h100 || mask_of(0) !== 32'hFFFFFFFF) begin failures++;
            $display("FAIL alloc_pc_mask got=%h/%h want=100/ffffffff", pc_of(0), mask_of(0)); end
        checks++; if (dp_of(0) !== 32'hA000 || idx_of(0) !== 4'd3) begin failures++;
            $display("FAIL alloc_dp_idx got=%h/%h want=a000/3", dp_of(0), idx_of(0)); end
        checks++; if (warp_free !== 1'b1) begin failures++; $display("FAIL alloc_free got=%b want=1", warp_free); end
    endtask

    task automatic test_divergence();
        sel = 4'b0001; tick();
        checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL sel_clears got=%b want=0", ready[0]); end
        set_dec(0, 0, 1, 32'h0000FFFF, 32'h104, 32'h200, 32'h300); tick();
        checks++; if (pc_of(0) !== 32'h200 || mask_of(0) !== 32'h0000FFFF || ready[0] !== 1'b1) begin failures++;
            $display("FAIL div_push got=%h/%h/%b want=200/0000ffff/1", pc_of(0), mask_of(0), ready[0]); end
        sel = 4'b0001; tick();
        set_dec(0, 0, 0, '0, 32'h300, 32'h0, 32'h0); tick();
        checks++; if (pc_of(0) !== 32'h300 || ready[0] !== 1'b0) begin failures++;
            $display("FAIL div_at_rpc got=%h/%b want=300/0", pc_of(0), ready[0]); end
        tick();
        checks++; if (pc_of(0) !== 32'h104 || mask_of(0) !== 32'hFFFF0000 || ready[0] !== 1'b1) begin failures++;
            $display("FAIL div_pop1 got=%h/%h/%b want=104/ffff0000/1", pc_of(0), mask_of(0), ready[0]); end
        sel = 4'b0001; tick();
        set_dec(0, 0, 0, '0, 32'h300, 32'h0, 32'h0); tick();
        checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL div_pend2 got=%b want=0", ready[0]); end
        tick();
        checks++; if (pc_of(0) !== 32'h300 || mask_of(0) !== 32'hFFFFFFFF || ready[0] !== 1'b1) begin failures++;
            $display("FAIL div_pop2 got=%h/%h/%b want=300/ffffffff/1", pc_of(0), mask_of(0), ready[0]); end
        tick();
        checks++; if (pc_of(0) !== 32'h300 || mask_of(0) !== 32'hFFFFFFFF) begin failures++;
            $display("FAIL div_empty got=%h/%h want=300/ffffffff", pc_of(0), mask_of(0)); end
    endtask

    task automatic test_uniform();
        sel = 4'b0001; tick();
        set_dec(0, 0, 1, 32'hFFFFFFFF, 32'h304, 32'h400, 32'h500); tick();
        checks++; if (pc_of(0) !== 32'h400 || mask_of(0) !== 32'hFFFFFFFF || ready[0] !== 1'b1) begin failures++;
            $display("FAIL uni_taken got=%h/%h/%b want=400/ffffffff/1", pc_of(0), mask_of(0), ready[0]); end
        sel = 4'b0001; tick();
        set_dec(0, 0, 1, 32'h0, 32'h404, 32'h600, 32'h700); tick();
        checks++; if (pc_of(0) !== 32'h404 || mask_of(0) !== 32'hFFFFFFFF) begin failures++;
            $display("FAIL uni_not_taken got=%h/%h want=404/ffffffff", pc_of(0), mask_of(0)); end
    endtask

    task automatic test_overflow();
        alloc = 1; a_pc = 32'h800; a_dp = 32'hB000; a_idx = 4'd1; a_id = 4'd9; tick();
        checks++; if (ready !== 4'b0011 || pc_of(1) !== 32'h800) begin failures++;
            $display("FAIL ovf_alloc got=%b/%h want=0011/800", ready, pc_of(1)); end
        sel = 4'b0010; tick();
        set_dec(1, 0, 1, 32'h00FF00FF, 32'h804, 32'h900, 32'hA00); tick();
        sel = 4'b0010; tick();
        set_dec(1, 0, 1, 32'h000000FF, 32'h904, 32'h950, 32'h980); tick();
        checks++; if (d_ovf !== 1'b1 || d_ovf_wid !== 2'd1) begin failures++;
            $display("FAIL ovf_pulse got=%b/%h want=1/1", d_ovf, d_ovf_wid); end
        tick(); tick();
        checks++; if (ready[1] !== 1'b0 || pc_of(1) !== 32'h900 || mask_of(1) !== 32'h00FF00FF) begin failures++;
            $display("FAIL ovf_halt got=%b/%h/%h want=0/900/00ff00ff", ready[1], pc_of(1), mask_of(1)); end
        checks++; if (ready[0] !== 1'b1 || pc_of(0) !== 32'h404) begin failures++;
            $display("FAIL ovf_other got=%b/%h want=1/404", ready[0], pc_of(0)); end
        sel = 4'b0001; tick();
        set_dec(0, 0, 1, 32'hFFFFFFFF, 32'h408, 32'h440, 32'h480); tick();
        checks++; if (d_ovf !== 1'b0 || pc_of(0) !== 32'h440) begin failures++;
            $display("FAIL ovf_other_dec got=%b/%h want=0/440", d_ovf, pc_of(0)); end
    endtask

    task automatic test_stop();
        sel = 4'b0001; tick();
        set_dec(0, 0, 1, 32'h0000FF00, 32'h444, 32'h700, 32'h780); tick();
        sel = 4'b0001; tick();
        set_dec(0, 1, 0, '0, '0, '0, '0); tick();
        checks++; if (d_done !== 1'b1 || d_done_id !== 4'd5) begin failures++;
            $display("FAIL stop_done got=%b/%h want=1/5", d_done, d_done_id); end
        checks++; if (ready[0] !== 1'b0 || warp_free !== 1'b1) begin failures++;
            $display("FAIL stop_free got=%b/%b want=0/1", ready[0], warp_free); end
        alloc = 1; a_pc = 32'h900; a_dp = 32'hC000; a_idx = 4'd2; a_id = 4'd7; tick();
        checks++; if (pc_of(0) !== 32'h900 || mask_of(0) !== 32'hFFFFFFFF || idx_of(0) !== 4'd2) begin failures++;
            $display("FAIL stop_realloc got=%h/%h/%h want=900/ffffffff/2", pc_of(0), mask_of(0), idx_of(0)); end
        sel = 4'b0001; tick();
        set_dec(0, 0, 1, 32'h0000000F, 32'h904, 32'hA00, 32'hB00); tick();
        checks++; if (d_ovf !== 1'b0 || mask_of(0) !== 32'h0000000F || pc_of(0) !== 32'hA00) begin failures++;
            $display("FAIL stop_sp_clear got=%b/%h/%h want=0/0000000f/a00", d_ovf, mask_of(0), pc_of(0)); end
    endtask

    task automatic test_full();
        alloc = 1; a_pc = 32'hC00; a_id = 4'd2; tick();
        alloc = 1; a_pc = 32'hD00; a_id = 4'd3; tick();
        checks++; if (warp_free !== 1'b0 || ready !== 4'b1101) begin failures++;
            $display("FAIL full_state got=%b/%b want=0/1101", warp_free, ready); end
        alloc = 1; a_pc = 32'hE00; tick();
        checks++; if (ready !== 4'b1101 || pc_of(2) !== 32'hC00 || pc_of(3) !== 32'hD00) begin failures++;
            $display("FAIL full_no_alloc got=%b/%h/%h want=1101/c00/d00", ready, pc_of(2), pc_of(3)); end
    endtask

    task automatic test_random();
        int inflight[$];
        int cand[$];
        int w, s;
        for (int ph = 0; ph < 6; ph++) begin
            rst_n = 0; tick(); rst_n = 1;
            inflight.delete();
            for (int cyc = 0; cyc < 80; cyc++) begin
                alloc = ($urandom_range(0, 3) == 0);
                a_pc = PW'($urandom_range(0, 1023)) << 2; a_dp = $urandom;
                a_idx = IXW'($urandom); a_id = IDW'($urandom);
                if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                    w = inflight.pop_front();
                    dec = 1; wid = WIDW'(w);
                    stop = ($urandom_range(0, 15) == 0);
                    br = ($urandom_range(0, 2) == 0);
                    case ($urandom_range(0, 3))
                        0: tmask = '0;
                        1: tmask = '1;
                        default: tmask = $urandom;
                    endcase
                    npc = (m_rpc[w] != '1 && $urandom_range(0, 2) == 0) ? m_rpc[w] : m_pc[w] + 32'd4;
                    tgt = PW'($urandom_range(0, 1023)) << 2;
                    rcv = PW'($urandom_range(0, 1023)) << 2;
                end
                cand.delete();
                for (int v = 0; v < NW; v++) if (m_ready(v)) cand.push_back(v);
                if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
                    s = cand[$urandom_range(0, cand.size() - 1)];
                    sel = NW'(1) << s;
                    inflight.push_back(s);
                end
                tick();
                checks++; if (d_free !== e_free) begin failures++; $display("FAIL rnd_free got=%b want=%b", d_free, e_free); end
                checks++; if (d_done !== e_done || d_done_id !== e_done_id) begin failures++;
                    $display("FAIL rnd_done got=%b/%h want=%b/%h", d_done, d_done_id, e_done, e_done_id); end
                checks++; if (d_ovf !== e_ovf || d_ovf_wid !== e_ovf_wid) begin failures++;
                    $display("FAIL rnd_ovf got=%b/%h want=%b/%h", d_ovf, d_ovf_wid, e_ovf, e_ovf_wid); end
                for (int v = 0; v < NW; v++) begin
                    checks++; if (ready[v] !== m_ready(v)) begin failures++;
                        $display("FAIL rnd_ready w=%0d got=%b want=%b", v, ready[v], m_ready(v)); end
                    checks++; if (pc_of(v) !== m_pc[v] || mask_of(v) !== m_mask[v]) begin failures++;
                        $display("FAIL rnd_pc_mask w=%0d got=%h/%h want=%h/%h", v, pc_of(v), mask_of(v), m_pc[v], m_mask[v]); end
                    checks++; if (dp_of(v) !== m_dp[v] || idx_of(v) !== m_idx[v]) begin failures++;
                        $display("FAIL rnd_dp_idx w=%0d got=%h/%h want=%h/%h", v, dp_of(v), idx_of(v), m_dp[v], m_idx[v]); end
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_divergence();
        test_uniform();
        test_overflow();
        test_stop();
        test_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
